// File: rtl/rgb2hsv_pipe.sv
// rgb2hsv_pipe -- four-stage RGB to HSV converter with valid/ready flow control.
//
// Stages:
//   1: max / min / hue sector (tie priority R, then G, then B)
//   2: delta = max - min and the signed channel difference for the sector
//   3: hue quotient 60*diff/delta (signed, truncated toward zero) and
//      saturation delta*(2^CW-1)/max; both dividers are bypassed when
//      their divisor would be zero
//   4: sector offset, wrap of negative hue by +360, pack into out_hsv
//
// Ports:
//   pclk, rst   clock and synchronous active-high reset
//   in_valid    input pixel present
//   in_ready    input accepted this cycle
//   in_rgb      {R, G, B}, CW bits each, R in the MSBs
//   in_user     UW-bit sideband tag, passed through unchanged
//   out_valid   result present
//   out_ready   downstream accepts the result
//   out_hsv     {H[8:0], S[CW-1:0], V[CW-1:0]}
//   out_user    tag aligned with out_hsv
//   px_count    16-bit output-transfer counter, only present when the
//               macro RGB2HSV_PIXCNT_EN is defined
//
// Handshake: a transfer happens on a pclk edge where valid and ready are
// both high on that interface. The whole pipeline advances as one unit
// unless the output is stalled (out_valid && !out_ready); during a stall
// every stage holds. in_ready is !stall && !rst, so an input can enter on
// the same edge that the output drains.
module rgb2hsv_pipe #(
  parameter int CW = 8,
  parameter int UW = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*CW-1:0]   in_rgb,
  input  logic [UW-1:0]     in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8+2*CW:0]   out_hsv,
  output logic [UW-1:0]     out_user
`ifdef RGB2HSV_PIXCNT_EN
  ,
  output logic [15:0]       px_count
`endif
);

  // Hue arithmetic width: |60*diff| < 2^(CW+6), plus sign and headroom.
  localparam int HW = CW + 8;
  localparam int SW = 2 * CW;

  localparam logic signed [HW-1:0] H_ONE   = HW'(1);
  localparam logic signed [HW-1:0] H_SIXTY = HW'(60);
  localparam logic signed [HW-1:0] H_120   = HW'(120);
  localparam logic signed [HW-1:0] H_240   = HW'(240);
  localparam logic signed [HW-1:0] H_360   = HW'(360);
  localparam logic [CW-1:0]        CMAX    = '1;

  typedef enum logic [1:0] {
    SEC_R = 2'd0,
    SEC_G = 2'd1,
    SEC_B = 2'd2
  } sector_t;

  logic stall;

  // ---------------- stage 1: max / min / sector ----------------
  logic [CW-1:0] in_r, in_g, in_b;
  logic [CW-1:0] c1_max, c1_min;
  sector_t       c1_sec;

  assign {in_r, in_g, in_b} = in_rgb;

  always_comb begin
    c1_sec = SEC_R;
    c1_max = in_r;
    if (in_r >= in_g && in_r >= in_b) begin
      c1_sec = SEC_R;
      c1_max = in_r;
    end else if (in_g >= in_b) begin
      c1_sec = SEC_G;
      c1_max = in_g;
    end else begin
      c1_sec = SEC_B;
      c1_max = in_b;
    end
    c1_min = in_r;
    if (in_g < c1_min) c1_min = in_g;
    if (in_b < c1_min) c1_min = in_b;
  end

  logic          s1_v;
  logic [CW-1:0] s1_r, s1_g, s1_b, s1_max, s1_min;
  sector_t       s1_sec;
  logic [UW-1:0] s1_user;

  // ---------------- stage 2: delta / diff ----------------
  logic [CW-1:0]        c2_delta;
  logic signed [CW:0]   c2_diff;

  always_comb begin
    c2_delta = s1_max - s1_min;
    c2_diff  = '0;
    case (s1_sec)
      SEC_R:   c2_diff = $signed({1'b0, s1_g}) - $signed({1'b0, s1_b});
      SEC_G:   c2_diff = $signed({1'b0, s1_b}) - $signed({1'b0, s1_r});
      default: c2_diff = $signed({1'b0, s1_r}) - $signed({1'b0, s1_g});
    endcase
  end

  logic               s2_v;
  logic [CW-1:0]      s2_max, s2_delta;
  logic signed [CW:0] s2_diff;
  sector_t            s2_sec;
  logic [UW-1:0]      s2_user;

  // ---------------- stage 3: dividers ----------------
  logic signed [HW-1:0] diff_ext, h_num, h_den, h_quo;
  logic [SW-1:0]        s_num, s_den, s_quo;
  logic [CW-1:0]        c3_s;

  always_comb begin
    diff_ext = HW'(s2_diff);
    h_num    = diff_ext * H_SIXTY;
    // A zero divisor is replaced by 1 so the divider never sees it; the
    // quotient is then forced to the bypass value anyway.
    h_den    = $signed({8'd0, s2_delta});
    if (s2_delta == '0) h_den = H_ONE;
    h_quo    = h_num / h_den;
    if (s2_delta == '0) h_quo = '0;

    s_num    = SW'(s2_delta) * SW'(CMAX);
    s_den    = SW'(s2_max);
    if (s2_max == '0) s_den = SW'(1);
    s_quo    = s_num / s_den;
    c3_s     = CW'(s_quo);
    if (s2_max == '0) c3_s = '0;
  end

  logic                 s3_v;
  logic signed [HW-1:0] s3_hq;
  logic [CW-1:0]        s3_s, s3_val;
  sector_t              s3_sec;
  logic [UW-1:0]        s3_user;

  // ---------------- stage 4: offset / wrap / pack ----------------
  logic signed [HW-1:0] h_off, h_sum, h_wrap;
  logic [8:0]           c4_h;

  always_comb begin
    h_off = '0;
    case (s3_sec)
      SEC_G:   h_off = H_120;
      SEC_B:   h_off = H_240;
      default: h_off = '0;
    endcase
    h_sum  = s3_hq + h_off;
    // Only the R sector can go negative (down to -60).
    h_wrap = h_sum[HW-1] ? (h_sum + H_360) : h_sum;
    c4_h   = 9'(h_wrap);
  end

  logic s4_v;

  assign out_valid = s4_v;
  assign stall     = s4_v && !out_ready;
  assign in_ready  = !stall && !rst;

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_max   <= '0;
      s1_min   <= '0;
      s1_sec   <= SEC_R;
      s1_user  <= '0;
      s2_v     <= 1'b0;
      s2_max   <= '0;
      s2_delta <= '0;
      s2_diff  <= '0;
      s2_sec   <= SEC_R;
      s2_user  <= '0;
      s3_v     <= 1'b0;
      s3_hq    <= '0;
      s3_s     <= '0;
      s3_val   <= '0;
      s3_sec   <= SEC_R;
      s3_user  <= '0;
      s4_v     <= 1'b0;
      out_hsv  <= '0;
      out_user <= '0;
    end else if (!stall) begin
      // in_ready is high whenever this branch runs, so in_valid alone
      // marks an accepted pixel.
      s1_v     <= in_valid;
      s1_r     <= in_r;
      s1_g     <= in_g;
      s1_b     <= in_b;
      s1_max   <= c1_max;
      s1_min   <= c1_min;
      s1_sec   <= c1_sec;
      s1_user  <= in_user;

      s2_v     <= s1_v;
      s2_max   <= s1_max;
      s2_delta <= c2_delta;
      s2_diff  <= c2_diff;
      s2_sec   <= s1_sec;
      s2_user  <= s1_user;

      s3_v     <= s2_v;
      s3_hq    <= h_quo;
      s3_s     <= c3_s;
      s3_val   <= s2_max;
      s3_sec   <= s2_sec;
      s3_user  <= s2_user;

      s4_v     <= s3_v;
      // Output data only changes when a real pixel arrives, so bubbles
      // leave the last result in place.
      if (s3_v) begin
        out_hsv  <= {c4_h, s3_s, s3_val};
        out_user <= s3_user;
      end
    end
  end

`ifdef RGB2HSV_PIXCNT_EN
  always_ff @(posedge pclk) begin
    if (rst) begin
      px_count <= '0;
    end else if (out_valid && out_ready) begin
      px_count <= px_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Testbench for rgb2hsv_pipe (CW=8, UW=2). A scoreboard queue receives the
// expected {hsv, user} word when a pixel is accepted and is checked in
// order against every output transfer.
module tb_rgb2hsv_pipe;

  localparam int CW   = 8;
  localparam int UW   = 2;
  localparam int HSVW = 9 + 2 * CW;
  localparam int OW   = HSVW + UW;
  localparam int CMAX = (1 << CW) - 1;

  logic              pclk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3*CW-1:0]   in_rgb;
  logic [UW-1:0]     in_user;
  logic              out_valid;
  logic              out_ready;
  logic [HSVW-1:0]   out_hsv;
  logic [UW-1:0]     out_user;
`ifdef RGB2HSV_PIXCNT_EN
  logic [15:0]       px_count;
`endif

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_word;
  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int px_exp = 0;

  rgb2hsv_pipe #(.CW(CW), .UW(UW)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .in_user   (in_user),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hsv   (out_hsv),
    .out_user  (out_user)
`ifdef RGB2HSV_PIXCNT_EN
    ,
    .px_count  (px_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] model(input int r, input int g, input int b,
                                          input logic [UW-1:0] u);
    int mx, mn, d, h, s;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d  = mx - mn;
    s  = (mx == 0) ? 0 : (d * CMAX) / mx;
    if (d == 0)                  h = 0;
    else if (r >= g && r >= b)   h = (60 * (g - b)) / d;
    else if (g >= b)             h = 120 + (60 * (b - r)) / d;
    else                         h = 240 + (60 * (r - g)) / d;
    if (h < 0) h = h + 360;
    return {9'(h), CW'(s), CW'(mx), u};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic scoreboard();
    forever begin
      @(negedge pclk);
      if (!rst && out_valid && out_ready) begin
        px_exp++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got hsv=%h user=%h, expected no output", out_hsv, out_user);
        end else begin
          exp_word = exp_q.pop_front();
          if ({out_hsv, out_user} !== exp_word) begin
            bad++;
            $display("FAIL sb_data: got h=%0d s=%0d v=%0d u=%0d, expected h=%0d s=%0d v=%0d u=%0d",
                     out_hsv[HSVW-1 -: 9], out_hsv[2*CW-1 -: CW], out_hsv[CW-1:0], out_user,
                     exp_word[OW-1 -: 9], exp_word[2*CW+UW-1 -: CW], exp_word[CW+UW-1 -: CW],
                     exp_word[UW-1:0]);
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3*CW-1:0] rgb, input logic [UW-1:0] u,
                      input logic [OW-1:0] e);
    int w;
    in_rgb   = rgb;
    in_user  = u;
    in_valid = 1'b1;
    w = 0;
    @(negedge pclk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge pclk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, w);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge pclk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [UW-1:0] u);
    int r, g, b;
    if ($urandom_range(0, 3) == 0) begin
      // Restricted alphabet to provoke max ties and delta==0.
      r = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 128 : 255);
      g = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 128 : 255);
      b = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 128 : 255);
    end else begin
      r = $urandom_range(0, CMAX);
      g = $urandom_range(0, CMAX);
      b = $urandom_range(0, CMAX);
    end
    send({CW'(r), CW'(g), CW'(b)}, u, model(r, g, b, u));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(posedge pclk);
      w++;
    end
    @(posedge pclk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_rgb    = '0;
    in_user   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    if (out_hsv !== '0)     begin bad++; $display("FAIL rst_out_hsv: got %h, expected 0", out_hsv); end
    if (out_user !== '0)    begin bad++; $display("FAIL rst_out_user: got %h, expected 0", out_user); end
    if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
    @(posedge pclk);
    #1;
    rst = 1'b0;
    @(negedge pclk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid: got %b, expected 0", out_valid); end
    if (out_hsv !== '0)     begin bad++; $display("FAIL post_rst_out_hsv: got %h, expected 0", out_hsv); end
    if (out_user !== '0)    begin bad++; $display("FAIL post_rst_out_user: got %h, expected 0", out_user); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready); end
`ifdef RGB2HSV_PIXCNT_EN
    total++;
    if (px_count !== 16'd0) begin bad++; $display("FAIL rst_px_count: got %0d, expected 0", px_count); end
`endif
    @(posedge pclk);
    #1;
  endtask

  task automatic test_vectors();
    int vr[7] = '{255, 205, 205, 255, 100,   0, 100};
    int vg[7] = '{255, 255,  55,  55,  50,   0, 100};
    int vb[7] = '{155,  55, 255, 155,  50,   0, 100};
    int eh[7] = '{ 60,  75, 285, 330,   0,   0,   0};
    int es[7] = '{100, 200, 200, 200, 127,   0,   0};
    int ev[7] = '{255, 255, 255, 255, 100,   0, 100};
    logic [UW-1:0] u;
    for (int i = 0; i < 7; i++) begin
      u = UW'(i + 1);
      send({CW'(vr[i]), CW'(vg[i]), CW'(vb[i])}, u, {9'(eh[i]), CW'(es[i]), CW'(ev[i]), u});
      repeat ($urandom_range(0, 2)) begin
        @(posedge pclk);
        #1;
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    logic exp_v;
    out_ready = 1'b1;
    t0 = cyc;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          int r, g, b;
          r = $urandom_range(0, CMAX);
          g = $urandom_range(0, CMAX);
          b = $urandom_range(0, CMAX);
          in_rgb   = {CW'(r), CW'(g), CW'(b)};
          in_user  = UW'(i);
          in_valid = 1'b1;
          exp_q.push_back(model(r, g, b, UW'(i)));
          @(negedge pclk);
          total++;
          if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b, expected 1", in_ready); end
          @(posedge pclk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 11; k++) begin
          @(negedge pclk);
          exp_v = (cyc >= t0 + 4) && (cyc <= t0 + 8);
          total++;
          if (out_valid !== exp_v) begin
            bad++;
            $display("FAIL b2b_timing: cycle +%0d out_valid=%b, expected %b", cyc - t0, out_valid, exp_v);
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_stall();
    logic [HSVW-1:0] held_hsv;
    logic [UW-1:0]   held_user;
    int w;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(UW'(i));
      end
      begin
        w = 0;
        @(negedge pclk);
        while (!out_valid && w < 100) begin
          w++;
          @(negedge pclk);
        end
        total++;
        if (!out_valid) begin bad++; $display("FAIL stall_start: out_valid=%b, expected 1", out_valid); end
        @(posedge pclk);
        #1;
        out_ready = 1'b0;
        held_hsv  = out_hsv;
        held_user = out_user;
        repeat (3) begin
          @(negedge pclk);
          total += 4;
          if (in_ready !== 1'b0)    begin bad++; $display("FAIL stall_in_ready: got %b, expected 0", in_ready); end
          if (out_valid !== 1'b1)   begin bad++; $display("FAIL stall_out_valid: got %b, expected 1", out_valid); end
          if (out_hsv !== held_hsv) begin bad++; $display("FAIL stall_hsv: got %h, expected %h", out_hsv, held_hsv); end
          if (out_user !== held_user) begin bad++; $display("FAIL stall_user: got %h, expected %h", out_user, held_user); end
        end
        @(posedge pclk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_rand(UW'(i));
    rst = 1'b1;
    exp_q.delete();
    @(negedge pclk);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b, expected 0", out_valid); end
    if (in_ready !== 1'b0)  begin bad++; $display("FAIL mid_rst_in_ready: got %b, expected 0", in_ready); end
    @(posedge pclk);
    #1;
    rst    = 1'b0;
    px_exp = 0;
    @(negedge pclk);
    total += 2;
    if (out_hsv !== '0)  begin bad++; $display("FAIL mid_post_hsv: got %h, expected 0", out_hsv); end
    if (out_user !== '0) begin bad++; $display("FAIL mid_post_user: got %h, expected 0", out_user); end
`ifdef RGB2HSV_PIXCNT_EN
    total++;
    if (px_count !== 16'd0) begin bad++; $display("FAIL mid_px_count: got %0d, expected 0", px_count); end
`endif
    for (int k = 0; k < 6; k++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_flush: cycle %0d out_valid=%b, expected 0", k, out_valid); end
      @(negedge pclk);
    end
    @(posedge pclk);
    #1;
    for (int i = 0; i < 2; i++) send_rand(UW'(i + 2));
    drain();
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_rand(UW'($urandom_range(0, (1 << UW) - 1)));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
              @(posedge pclk);
              #1;
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge pclk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
`ifdef RGB2HSV_PIXCNT_EN
    total++;
    if (px_count !== 16'(px_exp)) begin bad++; $display("FAIL px_count: got %0d, expected %0d", px_count, px_exp); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb2hsv_pipe.md
RGB2HSV_PIPE -- requirements
Module: rgb2hsv_pipe

Interface
REQ-001 SHALL have parameter CW, default 8: bits per colour channel, legal range 4..12.
REQ-002 SHALL have parameter UW, default 1: width of a user sideband tag carried alongside each pixel.
REQ-003 SHALL have port pclk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port in_valid, input, 1: input pixel present.
REQ-006 SHALL have port in_ready, output, 1: block accepts the input pixel this cycle.
REQ-007 SHALL have port in_rgb, input, 3*CW: packed {R, G, B}, with R in the MSBs.
REQ-008 SHALL have port in_user, input, UW: sideband tag, passed through unchanged.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port out_hsv, output, 9+2*CW: packed {H[8:0], S[CW-1:0], V[CW-1:0]}.
REQ-012 SHALL have port out_user, output, UW: tag aligned with out_hsv.

Function
REQ-013 SHALL treat a transfer as valid&&ready high on the same pclk edge, on each interface.
REQ-014 SHALL compute max, min and delta=max-min. On a max tie, the sector priority SHALL be R, then G, then B.
REQ-015 SHALL set V=max.
REQ-016 SHALL set S=0 when max==0. Otherwise S=floor(delta*(2^CW-1)/max).
REQ-017 SHALL set H=0 when delta==0.
REQ-018 SHALL compute H in the R sector as 60*(G-B)/delta.
REQ-019 SHALL compute H in the G sector as 120+60*(B-R)/delta.
REQ-020 SHALL compute H in the B sector as 240+60*(R-G)/delta.
REQ-021 SHALL compute the H quotient signed and truncated toward zero. A negative H result SHALL have 360 added, giving H in 0..359.
REQ-022 SHALL never divide by zero. The max==0 and delta==0 cases SHALL bypass the dividers.
REQ-023 SHALL be a 4-stage pipeline:
- stage 1: max/min/sector;
- stage 2: delta/diff;
- stage 3: divide;
- stage 4: offset/wrap/pack.
REQ-024 SHALL present out_valid exactly 4 pclk edges after an input transfer when no stall occurs.
REQ-025 SHALL sustain throughput of one pixel per pclk while out_ready is held high.
REQ-026 SHALL define stall = out_valid && !out_ready. During stall every stage SHALL hold, and out_hsv/out_user SHALL stay stable.
REQ-027 SHALL drive in_ready = !stall && !rst, combinationally.
REQ-028 SHALL let bubbles (empty stages) advance while not stalled. Bubbles SHALL never produce out_valid.
REQ-029 SHALL preserve pixel order. No pixel SHALL be dropped or duplicated under any valid/ready pattern.
REQ-030 SHALL accept a new input on the same edge that the output drains when both transfers occur simultaneously.

Reset
REQ-031 SHALL, on rst high at a pclk edge, clear all stage valid bits, discarding in-flight pixels.
REQ-032 SHALL drive out_valid=0, out_hsv=0 and out_user=0 while in reset and on the first cycle after reset.
REQ-033 SHALL, when reset is asserted mid-stream, produce no output from pixels accepted before reset.

Configuration
REQ-034 SHALL, when macro RGB2HSV_PIXCNT_EN is defined, add output port px_count, 16 bits.
REQ-035 SHALL increment px_count on each output transfer, wrapping 65535 to 0, and clear it to 0 on rst.
REQ-036 SHALL omit port px_count and its logic entirely when RGB2HSV_PIXCNT_EN is undefined, with all other behaviour identical.

Verification (CW=8)
REQ-037 SHALL cover hue sectors with single pixels:
- (255,255,155) -> H=60, S=100, V=255;
- (205,255,55) -> H=75, S=200, V=255;
- (205,55,255) -> H=285, S=200, V=255.
REQ-038 SHALL cover wrap and truncation:
- (255,55,155) -> H=330, S=200, V=255;
- (100,50,50) -> H=0, S=127, V=100.
REQ-039 SHALL cover zero-division cases:
- (0,0,0) -> H=0, S=0, V=0;
- (100,100,100) -> H=0, S=0, V=100.
REQ-040 SHALL stream 5 back-to-back pixels with out_ready=1, requiring results on 5 consecutive cycles starting 4 cycles after the first accept, in order, with out_user matching each input.
REQ-041 SHALL drop out_ready for 3 cycles mid-stream, requiring in_ready=0 and a stable out_hsv throughout, then in-order resumption with no loss.
REQ-042 SHALL assert rst for 1 cycle with 3 pixels in flight, requiring out_valid=0 until new inputs arrive and, with RGB2HSV_PIXCNT_EN defined, px_count=0.
